// File: rtl/mult_arbiter_pkg.sv
// Shared encodings for the dual-lane multiplier arbiter.
package mult_arbiter_pkg;

    localparam int MULT_WIDTH_DEFAULT = 32;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Which execute lane currently owns the multiplier
    typedef enum logic [1:0] {
        NONE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2
    } owner_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Lane request/stall bundle between the two E stages and the multiplier arbiter.
//
// Handshake: a lane presents req with its operands and keeps them stable while
// stall is high. A request is effective only when flush is low. The product
// commits at the edge that ends the cycle in which done is high; stall is low in
// that same cycle, so the lane advances on exactly that edge.
interface mult_arbiter_if #(
    parameter int WIDTH = 32
);
    import mult_arbiter_pkg::*;

    logic             req1;
    logic             signed1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             flush1;
    logic             req2;
    logic             signed2;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic             flush2;

    logic             stall1;
    logic             stall2;
    logic             done1;
    logic             done2;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Debug view of the arbiter FSM
    state_e           dbg_state;
    owner_e           dbg_owner;

    modport master (
        output req1, signed1, a1, b1, flush1,
        output req2, signed2, a2, b2, flush2,
        input  stall1, stall2, done1, done2, busy, hi, lo,
        input  dbg_state, dbg_owner
    );

    modport slave (
        input  req1, signed1, a1, b1, flush1,
        input  req2, signed2, a2, b2, flush2,
        output stall1, stall2, done1, done2, busy, hi, lo,
        output dbg_state, dbg_owner
    );

endinterface

// File: rtl/mult_arbiter_shift_add_mult_core.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step.
// The multiplier sits in the low half of the accumulator and is shifted out as
// partial sums enter from the top; after WIDTH steps the accumulator is a*b.
module shift_add_mult_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     sum;

    // Load operands on start, otherwise add-and-shift once per step
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        if (start) begin
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            mcand_d = a_mag;
        end else if (step) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    // Accumulator and multiplicand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier and HI/LO between execute lanes 1 and 2.
// Lane 1 is older in program order and wins simultaneous requests; lane 2 is
// chained straight from DONE into BUSY when it is waiting behind lane 1.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               v1, v2;
    logic               load1, load2;
    logic               core_start, core_step;
    logic [WIDTH-1:0]   core_a, core_b;
    logic [2*WIDTH-1:0] core_acc;
    logic [2*WIDTH-1:0] product;

    // Magnitude of a possibly signed operand; the most negative value maps to
    // 2^(WIDTH-1), which is representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        if (sgn && x[WIDTH-1]) begin
            return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        return x;
    endfunction

    assign v1 = bus.req1 & ~bus.flush1;
    assign v2 = bus.req2 & ~bus.flush2;

    // Sign-corrected product of the finished multiply
    assign product = neg_q ? ((~core_acc) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : core_acc;

    shift_add_mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .start (core_start),
        .step  (core_step),
        .a_mag (core_a),
        .b_mag (core_b),
        .acc   (core_acc)
    );

    // Next-state, owner selection, operand latching and HI/LO commit
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        count_d    = count_q;
        neg_d      = neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        load1      = 1'b0;
        load2      = 1'b0;
        core_start = 1'b0;
        core_step  = 1'b0;
        core_a     = '0;
        core_b     = '0;

        unique case (state_q)
            IDLE: begin
                if (v1) begin
                    load1 = 1'b1;
                end else if (v2) begin
                    load2 = 1'b1;
                end
            end
            BUSY: begin
                core_step = 1'b1;
                if ((owner_q == L1 && bus.flush1) || (owner_q == L2 && bus.flush2)) begin
                    // Owner squashed: drop the multiply, HI/LO untouched
                    state_d = IDLE;
                    owner_d = NONE;
                    count_d = '0;
                end else if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                hi_d = product[2*WIDTH-1:WIDTH];
                lo_d = product[WIDTH-1:0];
                // req1 still shows the completing instruction, so only lane 2 chains
                if (owner_q == L1 && v2) begin
                    load2 = 1'b1;
                end else begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
                count_d = '0;
            end
        endcase

        if (load1) begin
            core_start = 1'b1;
            core_a     = magnitude(bus.a1, bus.signed1);
            core_b     = magnitude(bus.b1, bus.signed1);
            neg_d      = bus.signed1 & (bus.a1[WIDTH-1] ^ bus.b1[WIDTH-1]);
            owner_d    = L1;
            state_d    = BUSY;
            count_d    = '0;
        end else if (load2) begin
            core_start = 1'b1;
            core_a     = magnitude(bus.a2, bus.signed2);
            core_b     = magnitude(bus.b2, bus.signed2);
            neg_d      = bus.signed2 & (bus.a2[WIDTH-1] ^ bus.b2[WIDTH-1]);
            owner_d    = L2;
            state_d    = BUSY;
            count_d    = '0;
        end
    end

    // FSM, owner, iteration count, sign and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= NONE;
            count_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // A lane stalls on its own request except in the cycle its product commits
    always_comb begin
        bus.done1  = (state_q == DONE) && (owner_q == L1);
        bus.done2  = (state_q == DONE) && (owner_q == L2);
        bus.stall1 = v1 & ~reset & ~bus.done1;
        bus.stall2 = v2 & ~reset & ~bus.done2;
        bus.busy   = (state_q != IDLE);
        bus.hi     = hi_q;
        bus.lo     = lo_q;
        bus.dbg_state = state_q;
        bus.dbg_owner = owner_q;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: driver tasks issue lane requests and push
// the expected owner lane and product; a negedge monitor pops on every done
// pulse and checks HI/LO the cycle after the commit.
module tb_mult_arbiter;
    import mult_arbiter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(W)) bus();

    mult_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // {lane[1:0], product[2W-1:0]}
    logic [2*W+1:0] exp_q[$];
    logic           chk_pending = 1'b0;
    logic [2*W-1:0] chk_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop on each done pulse, check HI/LO once the commit edge has passed
    always @(negedge clk) begin
        logic [2*W+1:0] e;
        if (chk_pending) begin
            check("hilo_commit", {bus.hi, bus.lo}, chk_exp);
            chk_pending = 1'b0;
        end
        if (reset === 1'b0 && (bus.done1 === 1'b1 || bus.done2 === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'({bus.done2, bus.done1}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_lane", 64'({bus.done2, bus.done1}), 64'(e[2*W+1:2*W]));
                chk_exp     = e[2*W-1:0];
                chk_pending = 1'b1;
            end
        end
    end

    task automatic set_lane(input logic [1:0] lane, input logic req, input logic sgn,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        if (lane == 2'd1) begin
            bus.req1 = req; bus.signed1 = sgn; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req2 = req; bus.signed2 = sgn; bus.a2 = a; bus.b2 = b;
        end
    endtask

    // Isolated request: caller is just after a posedge with the arbiter idle
    task automatic run_lane(input logic [1:0] lane, input logic sgn, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2*W-1:0] prod, input string tag);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        set_lane(lane, 1'b1, sgn, a, b);
        exp_q.push_back({lane, prod});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((lane == 2'd1) ? bus.stall1 : bus.stall2) begin
                n++;
            end else begin
                got = (lane == 2'd1) ? bus.done1 : bus.done2;
                break;
            end
        end
        check({tag, " stall_cycles"}, 64'(n), 64'(W + 1));
        check({tag, " done_pulse"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        set_lane(lane, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check({tag, " busy_after"}, 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   s1, s2, busy_n, d1_at, d2_at, k2;
        logic seen_done1;

        bus.req1 = 1'b0; bus.signed1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.flush1 = 1'b0;
        bus.req2 = 1'b0; bus.signed2 = 1'b0; bus.a2 = '0; bus.b2 = '0; bus.flush2 = 1'b0;
        reset = 1'b1;

        // Reset held with lane 1 already requesting
        set_lane(2'd1, 1'b1, 1'b0, 32'd7, 32'd6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset stall1", 64'(bus.stall1), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done1", 64'(bus.done1), 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_lane(2'd1, 1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, "l1_multu_7x6");
        run_lane(2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "l2_multu_max");
        run_lane(2'd1, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "l1_mult_m3x5");
        run_lane(2'd2, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "l2_mult_minxmin");
        run_lane(2'd1, 1'b1, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, "l1_mult_7xm2");
        run_lane(2'd2, 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "l2_multu_2p31x2");
        run_lane(2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "l1_mult_m1xm1");

        // Simultaneous requests: lane 1 first, lane 2 chained from DONE
        set_lane(2'd1, 1'b1, 1'b0, 32'd3, 32'd4);
        set_lane(2'd2, 1'b1, 1'b0, 32'd5, 32'd6);
        exp_q.push_back({2'd1, 64'd12});
        exp_q.push_back({2'd2, 64'd30});
        s1 = 0; s2 = 0; busy_n = 0; d1_at = -1; d2_at = -1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (bus.stall1) s1++;
            if (bus.stall2) s2++;
            if (bus.busy) busy_n++;
            if (bus.done2) begin
                d2_at = k;
                break;
            end
            if (bus.done1) begin
                d1_at = k;
                @(posedge clk); #1;
                set_lane(2'd1, 1'b0, 1'b0, '0, '0);
            end
        end
        @(posedge clk); #1;
        set_lane(2'd2, 1'b0, 1'b0, '0, '0);
        check("dual stall1_cycles", 64'(s1), 64'(W + 1));
        check("dual done1_cycle", 64'(d1_at), 64'(W + 1));
        check("dual stall2_cycles", 64'(s2), 64'(2 * W + 2));
        check("dual done2_cycle", 64'(d2_at), 64'(2 * W + 2));
        check("dual busy_cycles", 64'(busy_n), 64'(2 * W + 2));
        @(negedge clk);
        check("dual busy_after", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;

        // Flush of lane 1 mid-multiply with lane 2 waiting
        run_lane(2'd1, 1'b0, 32'd3, 32'd4, 64'd12, "l1_prep");
        set_lane(2'd1, 1'b1, 1'b1, 32'd100, 32'd200);
        set_lane(2'd2, 1'b1, 1'b0, 32'd9, 32'd9);
        exp_q.push_back({2'd2, 64'd81});
        seen_done1 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (bus.done1) seen_done1 = 1'b1;
            @(posedge clk);
        end
        #1;
        bus.flush1 = 1'b1;
        @(negedge clk);
        check("flush stall1_masked", 64'(bus.stall1), 64'd0);
        check("flush state_busy", 64'(bus.dbg_state), 64'(BUSY));
        @(posedge clk); #1;
        bus.flush1 = 1'b0;
        set_lane(2'd1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("flush busy_drop", 64'(bus.busy), 64'd0);
        check("flush no_done1", 64'(seen_done1 | bus.done1), 64'd0);
        check("flush hilo_kept", {bus.hi, bus.lo}, 64'd12);
        check("flush stall2_held", 64'(bus.stall2), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush l2_accepted", 64'(bus.busy), 64'd1);
        check("flush owner_l2", 64'(bus.dbg_owner), 64'(L2));
        k2 = -1;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (bus.done2) begin
                k2 = k;
                break;
            end
        end
        check("flush done2_cycle", 64'(k2), 64'(W));
        @(posedge clk); #1;
        set_lane(2'd2, 1'b0, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one iterative shift-add multiplier and the architectural HI/LO registers between execute lanes 1 and 2 of the dual-issue pipeline.
- Accepts mult/multu requests from each lane's E stage and holds the requesting lane stalled until its product commits.
- Orders simultaneous requests by program order: lane 1 is older, so it is served first.
- Exports HI/LO and a busy flag; the hazard detector uses busy to hold mfhi/mflo in decode.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits; one multiply takes WIDTH iteration cycles.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req1  in  1  lane 1 E stage holds mult/multu
signed1  in  1  lane 1 op is mult (signed)
a1  in  WIDTH  lane 1 rs operand (already forwarded)
b1  in  WIDTH  lane 1 rt operand
flush1  in  1  lane 1 E stage flushed this cycle
req2, signed2, a2, b2, flush2  in  1/1/WIDTH/WIDTH/1  same meanings, lane 2
stall1  out  1  hold lane 1 E stage
stall2  out  1  hold lane 2 E stage
done1  out  1  one-cycle pulse: lane 1 product commits at this edge
done2  out  1  one-cycle pulse: lane 2 product commits at this edge
busy  out  1  multiply in flight or committing (state != IDLE)
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO

Behaviour:
- Reset: state IDLE, owner 0, count 0, hi = lo = 0, and accumulator and latched operands 0. All outputs 0 except hi/lo, which are 0. Reset mid-operation aborts with no done pulse.
- Effective requests: v1 = req1 & ~flush1; v2 = req2 & ~flush2.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If v1: latch lane 1 operands and sign, owner = 1, go to BUSY.
  - Else if v2: same for lane 2, owner = 2.
  - Else stay in IDLE.
- BUSY:
  - count runs 0..WIDTH-1; one multiplier bit is consumed per cycle.
  - At count == WIDTH-1, go to DONE.
  - flush of the owner lane: abort to IDLE. hi/lo are unchanged, no done pulse, pending request of the other lane is kept.
- DONE:
  - Apply the sign correction, then write the product to {hi, lo} at the clock edge.
  - done<owner> = 1 for this cycle.
  - Next state: if owner == 1 and v2, latch lane 2 and go directly to BUSY with owner = 2; else go to IDLE.
  - Lane 1's request is never restarted from DONE, because req1 still reflects the instruction that is completing.
- stallX (combinational):
  - 1 when reqX & ~flushX, except in DONE with owner == X.
  - Lane 2 therefore also stalls while lane 1 is served.
- Latency for an isolated request sampled in IDLE at cycle t:
  - BUSY t+1..t+WIDTH, DONE t+WIDTH+1.
  - stall high for cycles t..t+WIDTH (WIDTH+1 cycles).
  - New hi/lo visible from cycle t+WIDTH+2.
- Signed ops:
  - Multiply magnitudes.
  - neg = a[WIDTH-1] ^ b[WIDTH-1]; if neg, take the two's complement of the 2*WIDTH product.
  - The most-negative operand magnitude is 2^(WIDTH-1), handled unsigned without overflow.
- Unsigned ops: operands are used as-is, neg = 0.
- Back-to-back lanes: final hi/lo equal the lane 2 product (program order).

Decomposition:
- Shared include holds:
  - state encodings IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - owner encodings NONE = 2'd0, L1 = 2'd1, L2 = 2'd2.
- Sub-module shift_add_mult_core:
  - inputs: start, a/b magnitudes;
  - per-cycle shift-add iteration;
  - output: 2*WIDTH accumulator.
- The arbiter keeps the FSM, owner, sign handling, HI/LO and stalls.

Test Plan:
- Reset with req1 = 1, then release → during reset, stall1 = 0 and hi = lo = 0; after release, lane 1 is accepted and stall1 stays high for 33 cycles.
- Lane 1 multu 7*6 at cycle t → stall1 high t..t+32, done1 at t+33, then hi = 0x00000000, lo = 0x0000002A.
- Unsigned and signed corners:
  - lane 2 multu 0xFFFFFFFF*0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001;
  - mult -3*5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1;
  - mult 0x80000000*0x80000000 → hi = 0x40000000, lo = 0x00000000.
- Simultaneous req1 (3*4) and req2 (5*6) at t:
  - done1 at t+33 with lo = 12;
  - lane 2 goes BUSY t+34..t+65, done2 at t+66;
  - final hi = 0, lo = 30;
  - stall2 high t..t+65.
- Lane 1 mult in flight with hi/lo = 0/12 and flush1 at BUSY count 10:
  - FSM returns to IDLE next cycle, no done1, hi/lo stay 0/12, busy drops;
  - a pending req2 is accepted the cycle after.
